core_exclusive_monitor: RTL and testbench
=========================================

Name: core_exclusive_monitor

Overview:
- Local exclusive monitor that sequences LDREX/STREX/CLREX pairs issued by the core load/store unit.
- Holds one reservation tag per core and decides STREX pass/fail. Only a passing STREX is granted a memory write.
- Sits between the ldst decode/execute stage and the bus master. It snoops writes from other masters to break reservations.

Parameters:
- ADDR_BITS, 30, word-address width (byte address bits [31:2]).
- GRANULE_LOG2, 2, log2 of the reservation granule in words (default 16-byte granule).
- TIMEOUT_CYCLES, 0, reservation lifetime in cycles; 0 disables auto-expiry.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ldrex_valid  in  1  an exclusive load is being issued this cycle
- ldrex_addr  in  ADDR_BITS  word address of the exclusive load
- strex_valid  in  1  an exclusive store requests a check this cycle
- strex_addr  in  ADDR_BITS  word address of the exclusive store
- clrex  in  1  CLREX executed
- exception  in  1  exception entry or return; clears the reservation
- snoop_valid  in  1  another master wrote memory this cycle
- snoop_addr  in  ADDR_BITS  word address of that write
- strex_done  out  1  one-cycle pulse: the STREX result is valid
- strex_fail  out  1  status written to Rd: 0 = success, 1 = fail; valid with strex_done
- strex_write  out  1  grant to perform the bus write; asserted only with strex_done && !strex_fail
- busy  out  1  a STREX check is in flight; the core stalls new exclusives
- excl_open  out  1  1 = monitor in Open Access state (no reservation)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- States: OPEN, EXCL, CHECK.
- Reset values: state OPEN, tag 0, timeout counter 0, strex_done 0, strex_fail 0, strex_write 0, busy 0, excl_open 1.
- Tag = addr[ADDR_BITS-1:GRANULE_LOG2]. A match is equality of tags.

Event priority within a cycle (highest first):
1. Reset.
2. clrex or exception.
3. strex_valid.
4. ldrex_valid.
5. snoop.

State transitions:
- OPEN --ldrex--> EXCL. Latch the tag and load the counter with TIMEOUT_CYCLES.
- EXCL --ldrex--> EXCL. Re-latch the tag and reload the counter; the new address replaces the old one.
- EXCL --snoop match--> OPEN. A non-matching snoop is ignored.
- EXCL --counter reaches 1 (TIMEOUT_CYCLES > 0)--> OPEN. The counter decrements once per cycle while in EXCL.
- EXCL or OPEN --strex_valid--> CHECK. The pass condition is registered: state was EXCL, tag matches, and no snoop match in the same cycle.
- CHECK --> OPEN, always after exactly one cycle. In that cycle: strex_done=1, strex_fail=!pass, strex_write=pass, busy=1. The reservation is consumed whether or not the STREX passed (ARMv6 semantics).

Boundary cases:
- clrex or exception in the same cycle as strex_valid: forced fail. The STREX still completes through CHECK with strex_fail=1.
- clrex or exception while in CHECK: the result already registered stands.
- ldrex and snoop match in the same cycle: the reservation is not established; state stays or goes OPEN.
- ldrex while busy: ignored, and a simulation assertion fires. strex_valid while busy: same.
- ldrex and strex in the same cycle: strex wins, ldrex is dropped, assertion fires.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. It is unused when TIMEOUT_CYCLES = 0.
- excl_open = (state != EXCL).
- Latency: strex_valid at cycle N gives strex_done at N+1. There are no combinational paths from inputs to outputs.

Decomposition:
- Add to uarch.sv: typedef enum ex_mon_state {EX_OPEN, EX_EXCL, EX_CHECK}, and a typedef for the granule tag width derived from ADDR_BITS and GRANULE_LOG2.
- Add to isa.sv: constants STREX_STATUS_OK=0 and STREX_STATUS_FAIL=1.
- No sub-module. The timeout counter is small enough to stay inline.

Test Plan:
- ldrex 0x100, then strex 0x100 three cycles later -> strex_done at N+1, strex_fail=0, strex_write=1, then excl_open=1.
- ldrex 0x100, snoop 0x103 (same granule), then strex 0x100 -> strex_fail=1, strex_write=0. A snoop to 0x104 instead -> strex_fail=0.
- strex 0x200 with no prior ldrex -> strex_fail=1. Then ldrex 0x200, clrex, strex 0x200 -> strex_fail=1.
- TIMEOUT_CYCLES=8: ldrex, wait 8 cycles -> excl_open=1, strex fails. With strex at cycle 7 -> passes.
- ldrex 0x100 then ldrex 0x300, strex 0x100 -> fail. Repeat, then strex 0x300 -> pass.
- Exception in the same cycle as strex_valid -> strex_fail=1. Reset asserted while in CHECK -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/core_exclusive_monitor_pkg.sv
// Shared types and constants for the core local exclusive monitor.
//   ex_mon_state : monitor state encoding (OPEN / EXCL / CHECK)
//   ex_tag_t     : reservation-granule tag for the default address/granule sizing
//   STREX_STATUS_* : value written to Rd by a STREX
`timescale 1ns/1ps
package core_exclusive_monitor_pkg;

  localparam int unsigned EX_ADDR_BITS    = 30;
  localparam int unsigned EX_GRANULE_LOG2 = 2;
  localparam int unsigned EX_TAG_BITS     = EX_ADDR_BITS - EX_GRANULE_LOG2;

  typedef logic [EX_TAG_BITS-1:0] ex_tag_t;

  typedef enum logic [1:0] {
    EX_OPEN  = 2'd0,
    EX_EXCL  = 2'd1,
    EX_CHECK = 2'd2
  } ex_mon_state;

  localparam logic STREX_STATUS_OK   = 1'b0;
  localparam logic STREX_STATUS_FAIL = 1'b1;

  // Width of the reservation lifetime counter; at least one bit even when unused.
  function automatic int unsigned ex_cnt_bits(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/core_exclusive_monitor.sv
// Local exclusive monitor: tracks one LDREX reservation per core and decides
// STREX pass/fail. Writes from other masters (snoop) break a matching reservation.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ldrex_valid / ldrex_addr   exclusive load issue and word address
//   strex_valid / strex_addr   exclusive store check request and word address
//   clrex, exception           drop the reservation
//   snoop_valid / snoop_addr   write by another master
//   strex_done                 one-cycle result pulse (one cycle after strex_valid)
//   strex_fail                 Rd status, valid with strex_done
//   strex_write                bus write grant for a passing STREX
//   busy                       STREX check in flight
//   excl_open                  no reservation held
`timescale 1ns/1ps
module core_exclusive_monitor
  import core_exclusive_monitor_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 30,
  parameter int unsigned GRANULE_LOG2   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ldrex_valid,
  input  logic [ADDR_BITS-1:0] ldrex_addr,
  input  logic                 strex_valid,
  input  logic [ADDR_BITS-1:0] strex_addr,
  input  logic                 clrex,
  input  logic                 exception,
  input  logic                 snoop_valid,
  input  logic [ADDR_BITS-1:0] snoop_addr,
  output logic                 strex_done,
  output logic                 strex_fail,
  output logic                 strex_write,
  output logic                 busy,
  output logic                 excl_open
);

  localparam int unsigned TAG_BITS = ADDR_BITS - GRANULE_LOG2;
  localparam int unsigned CNT_BITS = ex_cnt_bits(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  ex_mon_state         state_q, state_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                write_q, write_d;
  logic                busy_q, busy_d;
  logic                open_q, open_d;

  logic [TAG_BITS-1:0] ld_tag, st_tag, sn_tag;
  logic                snp_hit_res;
  logic                snp_hit_ld;
  logic                strex_pass;

  assign ld_tag = ldrex_addr[ADDR_BITS-1:GRANULE_LOG2];
  assign st_tag = strex_addr[ADDR_BITS-1:GRANULE_LOG2];
  assign sn_tag = snoop_addr[ADDR_BITS-1:GRANULE_LOG2];

  // Word offsets inside a granule never affect a match.
  logic unused_lo;
  assign unused_lo = ^{ldrex_addr[GRANULE_LOG2-1:0], strex_addr[GRANULE_LOG2-1:0],
                       snoop_addr[GRANULE_LOG2-1:0]};

  assign snp_hit_res = snoop_valid && (sn_tag == tag_q);
  assign snp_hit_ld  = snoop_valid && (sn_tag == ld_tag);

  // Next state: clrex/exception > strex > ldrex > snoop/timeout.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    strex_pass = 1'b0;

    case (state_q)
      EX_CHECK: state_d = EX_OPEN;
      default: begin
        if (clrex || exception) begin
          // A STREX in the same cycle still completes, but always fails.
          state_d = strex_valid ? EX_CHECK : EX_OPEN;
        end else if (strex_valid) begin
          state_d    = EX_CHECK;
          strex_pass = (state_q == EX_EXCL) && (st_tag == tag_q) && !snp_hit_res;
        end else if (ldrex_valid) begin
          // A write to the target granule racing the load prevents the reservation.
          if (snp_hit_ld) begin
            state_d = EX_OPEN;
          end else begin
            state_d = EX_EXCL;
            tag_d   = ld_tag;
            cnt_d   = CNT_LOAD;
          end
        end else if (state_q == EX_EXCL) begin
          if (snp_hit_res) begin
            state_d = EX_OPEN;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (cnt_q == CNT_ONE) state_d = EX_OPEN;
            else                  cnt_d   = cnt_q - CNT_ONE;
          end
        end
      end
    endcase

    done_d  = (state_d == EX_CHECK);
    busy_d  = (state_d == EX_CHECK);
    fail_d  = (state_d == EX_CHECK) &&
              ((strex_pass ? STREX_STATUS_OK : STREX_STATUS_FAIL) == STREX_STATUS_FAIL);
    write_d = (state_d == EX_CHECK) && strex_pass;
    open_d  = (state_d != EX_EXCL);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EX_OPEN;
      tag_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      open_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      open_q  <= open_d;
    end
  end

  assign strex_done  = done_q;
  assign strex_fail  = fail_q;
  assign strex_write = write_q;
  assign busy        = busy_q;
  assign excl_open   = open_q;

`ifndef SYNTHESIS
  // Core must stall exclusives while a check is in flight, and never issue both at once.
  a_ldrex_busy: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && ldrex_valid))
    else $error("ldrex issued while busy");
  a_strex_busy: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && strex_valid))
    else $error("strex issued while busy");
  a_ld_st_same: assert property (@(posedge clk) disable iff (!rst_n) !(ldrex_valid && strex_valid))
    else $error("ldrex and strex issued in the same cycle");
`endif

endmodule

// File: tb/tb_core_exclusive_monitor.sv
`timescale 1ns/1ps
module tb_core_exclusive_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ldrex_valid, strex_valid, clrex, exception, snoop_valid;
  logic [29:0] ldrex_addr, strex_addr, snoop_addr;

  // Instance a: no timeout. Instance b: TIMEOUT_CYCLES = 8. Both see the same stimulus.
  logic a_done, a_fail, a_write, a_busy, a_open;
  logic b_done, b_fail, b_write, b_busy, b_open;

  always #5 clk = ~clk;

  core_exclusive_monitor #(.ADDR_BITS(30), .GRANULE_LOG2(2), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ldrex_valid(ldrex_valid), .ldrex_addr(ldrex_addr),
    .strex_valid(strex_valid), .strex_addr(strex_addr),
    .clrex(clrex), .exception(exception),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .strex_done(a_done), .strex_fail(a_fail), .strex_write(a_write),
    .busy(a_busy), .excl_open(a_open)
  );

  core_exclusive_monitor #(.ADDR_BITS(30), .GRANULE_LOG2(2), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ldrex_valid(ldrex_valid), .ldrex_addr(ldrex_addr),
    .strex_valid(strex_valid), .strex_addr(strex_addr),
    .clrex(clrex), .exception(exception),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .strex_done(b_done), .strex_fail(b_fail), .strex_write(b_write),
    .busy(b_busy), .excl_open(b_open)
  );

  typedef struct packed {
    int   cyc;
    logic fail;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: pop an expectation whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (a_done === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_done", 32'(a_done), 32'd0);
      end else begin
        e = qa.pop_front();
        check("a_done_cycle", 32'(cyc), 32'(e.cyc));
        check("a_fail", 32'(a_fail), 32'(e.fail));
        check("a_write", 32'(a_write), 32'(!e.fail));
        check("a_busy", 32'(a_busy), 32'd1);
      end
    end else begin
      check("a_write_idle", 32'(a_write), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_done === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 32'(b_done), 32'd0);
      end else begin
        e = qb.pop_front();
        check("b_done_cycle", 32'(cyc), 32'(e.cyc));
        check("b_fail", 32'(b_fail), 32'(e.fail));
        check("b_write", 32'(b_write), 32'(!e.fail));
        check("b_busy", 32'(b_busy), 32'd1);
      end
    end else begin
      check("b_write_idle", 32'(b_write), 32'd0);
    end
  end

  // One stimulus cycle: inputs applied just after a rising edge, cleared after the next.
  task automatic step(input logic ldv, input logic [29:0] lda,
                      input logic stv, input logic [29:0] sta,
                      input logic clr, input logic exc,
                      input logic snv, input logic [29:0] sna,
                      input logic fa, input logic fb);
    exp_t e;
    ldrex_valid = ldv; ldrex_addr = lda;
    strex_valid = stv; strex_addr = sta;
    clrex = clr; exception = exc;
    snoop_valid = snv; snoop_addr = sna;
    if (stv) begin
      e.cyc = cyc + 1; e.fail = fa; qa.push_back(e);
      e.fail = fb;                  qb.push_back(e);
    end
    @(posedge clk); #1;
    ldrex_valid = 1'b0; strex_valid = 1'b0; clrex = 1'b0;
    exception = 1'b0; snoop_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [29:0] a);
    step(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic ld_snoop(input logic [29:0] a, input logic [29:0] sa);
    step(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b1, sa, 1'b0, 1'b0);
  endtask

  task automatic snoop(input logic [29:0] sa);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, sa, 1'b0, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // STREX issue cycle only (the following cycle is the CHECK cycle).
  task automatic st_issue(input logic [29:0] a, input logic fa, input logic fb,
                          input logic exc = 1'b0, input logic snv = 1'b0,
                          input logic [29:0] sa = '0);
    step(1'b0, '0, 1'b1, a, 1'b0, exc, snv, sa, fa, fb);
  endtask

  // STREX plus a quiet CHECK cycle.
  task automatic st(input logic [29:0] a, input logic fa, input logic fb,
                    input logic exc = 1'b0, input logic snv = 1'b0,
                    input logic [29:0] sa = '0);
    st_issue(a, fa, fb, exc, snv, sa);
    idle(1);
  endtask

  // Check reservation status of both instances in the current cycle (uses one cycle).
  task automatic check_open(input string nm, input logic ea, input logic eb);
    @(negedge clk);
    check({nm, "_a_open"}, 32'(a_open), 32'(ea));
    check({nm, "_b_open"}, 32'(b_open), 32'(eb));
    check({nm, "_a_busy"}, 32'(a_busy), 32'd0);
    check({nm, "_b_busy"}, 32'(b_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string nm);
    @(negedge clk);
    check({nm, "_a_outs"}, 32'({a_done, a_fail, a_write, a_busy, a_open}), 32'b00001);
    check({nm, "_b_outs"}, 32'({b_done, b_fail, b_write, b_busy, b_open}), 32'b00001);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ldrex_valid = 1'b0; strex_valid = 1'b0; clrex = 1'b0;
    exception = 1'b0; snoop_valid = 1'b0;
    ldrex_addr = '0; strex_addr = '0; snoop_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("reset");

    // Basic pair: strex three cycles after ldrex passes; reservation consumed.
    ld(30'h100);
    check_open("after_ldrex", 1'b0, 1'b0);
    idle(1);
    st(30'h100, 1'b0, 1'b0);
    check_open("after_pass", 1'b1, 1'b1);

    // Snoop inside the granule breaks it; outside the granule does not.
    ld(30'h100);
    snoop(30'h103);
    check_open("snoop_hit", 1'b1, 1'b1);
    st(30'h100, 1'b1, 1'b1);
    ld(30'h100);
    snoop(30'h104);
    check_open("snoop_miss", 1'b0, 1'b0);
    st(30'h100, 1'b0, 1'b0);

    // No reservation, then reservation cleared by clrex.
    st(30'h200, 1'b1, 1'b1);
    ld(30'h200);
    clr();
    st(30'h200, 1'b1, 1'b1);

    // A second ldrex replaces the reserved address.
    ld(30'h100);
    ld(30'h300);
    st(30'h100, 1'b1, 1'b1);
    ld(30'h100);
    ld(30'h300);
    st(30'h300, 1'b0, 1'b0);

    // Exception or matching snoop in the strex cycle forces fail.
    ld(30'h100);
    st(30'h100, 1'b1, 1'b1, 1'b1);
    ld(30'h100);
    st(30'h100, 1'b1, 1'b1, 1'b0, 1'b1, 30'h101);

    // ldrex racing a matching snoop never establishes the reservation.
    ld_snoop(30'h100, 30'h102);
    check_open("ld_snoop", 1'b1, 1'b1);
    st(30'h100, 1'b1, 1'b1);

    // clrex during CHECK leaves the registered pass intact.
    ld(30'h140);
    st_issue(30'h141, 1'b0, 1'b0);
    clr();
    check_open("clrex_in_check", 1'b1, 1'b1);

    // Timeout: strex at the seventh cycle after the load still passes on both.
    ld(30'h100);
    idle(6);
    st(30'h100, 1'b0, 1'b0);
    // Reservation lives exactly 8 cycles on instance b, forever on instance a.
    ld(30'h100);
    idle(7);
    check_open("timeout_last", 1'b0, 1'b0);
    check_open("timeout_expired", 1'b0, 1'b1);
    st(30'h100, 1'b0, 1'b1);

    // Reset while in CHECK: the pending result shows, then reset values.
    ld(30'h180);
    st_issue(30'h180, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("reset_in_check");

    // Reset while holding a reservation drops it.
    ld(30'h180);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_open("reset_in_excl", 1'b1, 1'b1);
    st(30'h180, 1'b1, 1'b1);

    idle(3);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
